ahb_cmd_master: RTL and testbench
=================================

AHB_CMD_MASTER -- requirements
Module: ahb_cmd_master

Interface
REQ-001 SHALL have parameter: HPROT_VAL, 4'b0011, constant driven on HPROT (non-cacheable, privileged data).
REQ-002 SHALL have ports, clock and reset first:
- HCLK  in  1  clock; all logic on rising edge.
- HRESETn  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at edge.
- cmd_addr  in  32  byte address; bits [1:0] ignored.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle response strobe; no backpressure.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_err  out  1  1 = transfer ended with ERROR response.
- HADDR  out  32  AHB address.
- HTRANS  out  2  IDLE (00) or NONSEQ (10) only.
- HWRITE  out  1  AHB direction.
- HSIZE  out  3  constant 3'b010 (word).
- HBURST  out  3  constant 3'b000 (SINGLE).
- HPROT  out  4  constant HPROT_VAL.
- HWDATA  out  32  write data, valid in the data phase.
- HRDATA  in  32  read data.
- HREADY  in  1  transfer-complete / bus-ready.
- HRESP  in  1  0 = OKAY, 1 = ERROR.

Function
REQ-003 SHALL drive HADDR, HTRANS, HWRITE and HWDATA from registers; no combinational path from AHB inputs to these outputs.
REQ-004 SHALL drive HADDR[1:0] = 2'b00 for every transfer.
REQ-005 SHALL assert cmd_ready = HREADY & !replay & !(HRESP & !HREADY).
REQ-006 On an edge with HREADY = 1, SHALL load the address-phase registers:
- If a command is accepted: HTRANS = NONSEQ, HADDR = {cmd_addr[31:2], 2'b00}, HWRITE = cmd_write, and cmd_wdata is latched.
- Otherwise: HTRANS = IDLE, with HADDR and HWRITE held.
REQ-007 SHALL hold HADDR, HTRANS, HWRITE and the latched wdata stable while HREADY = 0, except as required by REQ-012.
REQ-008 On an edge with HREADY = 1 and HTRANS = NONSEQ, SHALL enter the data phase:
- dp_valid = 1, dp_write = HWRITE.
- HWDATA = latched wdata.
- HWDATA is held until the data phase completes.
REQ-009 SHALL support pipelining: the address phase of command N+1 overlaps the data phase of command N, so back-to-back commands issue one per cycle with zero wait states.
REQ-010 Data phase completes on an edge with dp_valid & HREADY. On the next cycle the block SHALL assert rsp_valid for exactly 1 cycle, with:
- rsp_err = HRESP sampled at completion.
- rsp_rdata = HRDATA for reads; 0 for writes or on error.
REQ-011 Command-to-response latency with zero wait states SHALL be 3 cycles:
- accept edge → address phase (1 cycle) → data phase (1 cycle) → rsp_valid.
- Each wait state adds 1 cycle.
REQ-012 Error handling, first ERROR cycle (HRESP = 1, HREADY = 0) with HTRANS = NONSEQ pending: on that edge the block SHALL set HTRANS = IDLE, retain HADDR/HWRITE/wdata, and set replay = 1.
REQ-013 Error handling, second ERROR cycle (HRESP = 1, HREADY = 1): the edge completes the errored data phase (rsp_err = 1) and the IDLE address phase. On the following edge the block SHALL reissue the retained command as NONSEQ and clear replay.
REQ-014 Responses SHALL be produced in command-acceptance order; one response per accepted command, including replayed commands.
REQ-015 HRDATA SHALL be sampled only at data-phase completion; HRDATA in any other cycle has no effect.

Reset
REQ-016 When HRESETn = 0, asynchronously:
- HTRANS = IDLE, HADDR = 0, HWRITE = 0, HWDATA = 0.
- dp_valid = 0, replay = 0.
- rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
REQ-017 cmd_ready SHALL be 0 while HRESETn = 0.
REQ-018 Reset during an active transfer SHALL discard all in-flight commands and produce no response for them. The first accepted command after reset release is issued normally.

Verification
REQ-019 Single write, slave with 0 wait states: cmd 0x53000004 wdata 0x1 → HTRANS = NONSEQ 1 cycle, HADDR = 0x53000004, then HWDATA = 0x1; rsp_valid 3 cycles after accept, rsp_err = 0.
REQ-020 Write then read: write 0x53000000 = 0xA5A5, then read 0x53000000 (slave returns 0x0000A5A5) → NONSEQ on 2 consecutive cycles; responses in order; second has rsp_rdata = 0x0000A5A5.
REQ-021 Wait states: read 0x53000000 with HREADY = 0 for 2 data-phase cycles → HWDATA, HADDR and HTRANS stable during the wait; rsp_valid 5 cycles after accept; cmd_ready = 0 while HREADY = 0.
REQ-022 Error with pipelined command: write A is followed by read B in its address phase, and the slave gives a 2-cycle ERROR on A → HTRANS goes IDLE in the second ERROR cycle; response A has rsp_err = 1; B is reissued as NONSEQ with the same HADDR and completes with rsp_err = 0.
REQ-023 Reset mid-transfer: HRESETn pulsed low while a data phase is waiting (HREADY = 0) → outputs reach their REQ-016 values immediately; no rsp_valid for the dropped command; next command is accepted normally.
REQ-024 Address alignment: cmd_addr 0x53000007 → HADDR = 0x53000004.

Source files
------------

// File: rtl/ahb_cmd_master.sv
// rtl/ahb_cmd_master.sv - pipelined AHB-Lite single-transfer command master
module ahb_cmd_master #(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic        cmd_write,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_NONSEQ = 2'b10
  } htrans_e;

  // Address-phase state (registered, drives the bus directly)
  htrans_e     r_htrans;
  htrans_e     w_htrans_nxt;
  logic [31:0] r_haddr;
  logic [31:0] w_haddr_nxt;
  logic        r_hwrite;
  logic        w_hwrite_nxt;
  logic [31:0] r_wdata;
  logic [31:0] w_wdata_nxt;
  logic        r_replay;
  logic        w_replay_nxt;

  // Data-phase state
  logic        r_dp_valid;
  logic        r_dp_write;
  logic [31:0] r_hwdata;

  // Response strobe
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [31:0] r_rsp_rdata;

  logic        w_cmd_ready;
  logic        w_accept;
  logic        w_dp_done;
  logic        w_err_first;
  logic        w_addr_nonseq;

  // A new command may only enter while the bus advances and no errored
  // command is waiting to be reissued; held low throughout reset.
  assign w_cmd_ready   = HRESETn & HREADY & ~r_replay & ~(HRESP & ~HREADY);
  assign w_accept      = cmd_valid & w_cmd_ready;
  assign w_dp_done     = r_dp_valid & HREADY;
  assign w_addr_nonseq = (r_htrans == TR_NONSEQ);
  // First cycle of a two-cycle ERROR with a transfer queued behind it: the
  // queued address phase must be cancelled and replayed later.
  assign w_err_first   = ~HREADY & HRESP & r_dp_valid & w_addr_nonseq;

  // Next address-phase contents: reissue, new command, cancel on error, or hold
  always_comb begin
    w_htrans_nxt = r_htrans;
    w_haddr_nxt  = r_haddr;
    w_hwrite_nxt = r_hwrite;
    w_wdata_nxt  = r_wdata;
    w_replay_nxt = r_replay;
    if (HREADY) begin
      if (r_replay) begin
        // While the errored data phase is still finishing the bus stays IDLE;
        // the retained command goes out on the edge after it has completed.
        if (!r_dp_valid) begin
          w_htrans_nxt = TR_NONSEQ;
          w_replay_nxt = 1'b0;
        end else begin
          w_htrans_nxt = TR_IDLE;
        end
      end else if (w_accept) begin
        w_htrans_nxt = TR_NONSEQ;
        w_haddr_nxt  = {cmd_addr[31:2], 2'b00};
        w_hwrite_nxt = cmd_write;
        w_wdata_nxt  = cmd_wdata;
      end else begin
        w_htrans_nxt = TR_IDLE;
      end
    end else if (w_err_first) begin
      w_htrans_nxt = TR_IDLE;
      w_replay_nxt = 1'b1;
    end
  end

  // Address-phase registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_htrans <= TR_IDLE;
      r_haddr  <= 32'h0;
      r_hwrite <= 1'b0;
      r_wdata  <= 32'h0;
      r_replay <= 1'b0;
    end else begin
      r_htrans <= w_htrans_nxt;
      r_haddr  <= w_haddr_nxt;
      r_hwrite <= w_hwrite_nxt;
      r_wdata  <= w_wdata_nxt;
      r_replay <= w_replay_nxt;
    end
  end

  // Data phase: a completed NONSEQ address phase becomes the active data phase
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_hwdata   <= 32'h0;
    end else if (HREADY) begin
      r_dp_valid <= w_addr_nonseq;
      if (w_addr_nonseq) begin
        r_dp_write <= r_hwrite;
        r_hwdata   <= r_wdata;
      end
    end
  end

  // Response: one-cycle strobe after each completed data phase
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0;
    end else begin
      r_rsp_valid <= w_dp_done;
      if (w_dp_done) begin
        r_rsp_err   <= HRESP;
        r_rsp_rdata <= (!r_dp_write && !HRESP) ? HRDATA : 32'h0;
      end
    end
  end

  assign cmd_ready = w_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign HADDR     = r_haddr;
  assign HTRANS    = r_htrans;
  assign HWRITE    = r_hwrite;
  assign HWDATA    = r_hwdata;
  assign HSIZE     = 3'b010;
  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VAL;

endmodule

// File: tb/tb_ahb_cmd_master.sv
// tb/tb_ahb_cmd_master.sv - randomized and directed bench for ahb_cmd_master
module tb_ahb_cmd_master;

  logic        HCLK;
  logic        HRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  ahb_cmd_master #(.HPROT_VAL(4'b0011)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP)
  );

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    int          acc;
  } cmd_t;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  cmd_t        exp_q[$];
  int          lat_q[$];
  logic [31:0] rd_q[$];
  logic        err_q[$];
  logic [31:0] ref_mem [logic [29:0]];
  logic [31:0] slv_mem [logic [29:0]];

  // slave behaviour controls and state
  logic        s_rand = 1'b0;
  int          dir_waits = 0;
  logic        s_dp_act, s_dp_write, s_dp_err;
  logic [31:0] s_dp_addr;
  int          s_cnt, s_w;
  logic        s_last_ready, s_last_resp, s_last_nonseq, s_last_write;
  logic [31:0] s_last_addr, s_last_hwdata;
  logic [1:0]  s_last_htrans;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [29:0] wa);
    return {2'b10, wa} ^ 32'h3C5A_0F96;
  endfunction

  function automatic bit is_err_addr(input logic [31:0] a);
    return a[31:28] == 4'hE;
  endfunction

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  initial forever begin
    @(posedge HCLK);
    cyc++;
  end

  // AHB slave: word memory, optional wait states, two-cycle ERROR on 0xE region
  initial begin
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
    s_dp_act = 1'b0; s_dp_write = 1'b0; s_dp_err = 1'b0; s_dp_addr = 32'h0;
    s_cnt = 0; s_w = 0;
    s_last_ready = 1'b1; s_last_resp = 1'b0; s_last_nonseq = 1'b0; s_last_write = 1'b0;
    s_last_addr = 32'h0; s_last_hwdata = 32'h0; s_last_htrans = 2'b00;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        s_dp_act = 1'b0; s_last_ready = 1'b1; s_last_resp = 1'b0; s_last_nonseq = 1'b0;
        HREADY = 1'b1; HRESP = 1'b0;
      end else begin
        if (s_last_ready) begin
          s_dp_act   = s_last_nonseq;
          s_dp_addr  = s_last_addr;
          s_dp_write = s_last_write;
          s_dp_err   = is_err_addr(s_last_addr);
          s_cnt      = 0;
          s_w        = s_rand ? (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0) : dir_waits;
          if (s_last_nonseq) check("haddr_align", {30'h0, s_last_addr[1:0]}, 32'h0);
        end else if (!s_last_resp) begin
          check("hold_haddr", HADDR, s_last_addr);
          check("hold_htrans", 32'(HTRANS), 32'(s_last_htrans));
          check("hold_hwdata", HWDATA, s_last_hwdata);
        end
        HRDATA = $urandom;
        HRESP  = 1'b0;
        HREADY = 1'b1;
        if (s_dp_act) begin
          if (s_cnt < s_w) begin
            HREADY = 1'b0;
          end else if (s_dp_err) begin
            HRESP  = 1'b1;
            HREADY = (s_cnt != s_w);
          end else if (s_dp_write) begin
            slv_mem[s_dp_addr[31:2]] = HWDATA;
          end else begin
            HRDATA = slv_mem.exists(s_dp_addr[31:2]) ? slv_mem[s_dp_addr[31:2]] : init_word(s_dp_addr[31:2]);
          end
          s_cnt++;
        end
        s_last_ready  = HREADY;
        s_last_resp   = HRESP;
        s_last_nonseq = (HTRANS == 2'b10);
        s_last_htrans = HTRANS;
        s_last_addr   = HADDR;
        s_last_write  = HWRITE;
        s_last_hwdata = HWDATA;
      end
    end
  end

  // cmd_ready must be low whenever the bus is stalled
  initial forever begin
    @(negedge HCLK);
    #2;
    if (!HREADY) check("cmd_ready_stall", 32'(cmd_ready), 32'h0);
  end

  // Response monitor against the in-order reference model
  initial begin : mon
    cmd_t        c;
    logic        e;
    logic [31:0] er;
    forever begin
      @(negedge HCLK);
      #1;
      if (HRESETn && rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'h0);
        end else begin
          c  = exp_q.pop_front();
          e  = is_err_addr(c.a);
          er = 32'h0;
          if (c.w) begin
            if (!e) ref_mem[c.a[31:2]] = c.d;
          end else if (!e) begin
            er = ref_mem.exists(c.a[31:2]) ? ref_mem[c.a[31:2]] : init_word(c.a[31:2]);
          end
          check("rsp_err", 32'(rsp_err), 32'(e));
          check("rsp_rdata", rsp_rdata, er);
          lat_q.push_back(cyc - c.acc);
          rd_q.push_back(rsp_rdata);
          err_q.push_back(rsp_err);
        end
      end
    end
  end

  // Present a command at a falling edge and hold it until accepted
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    int   g;
    cmd_t c;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    g = 0;
    #2;
    while (!cmd_ready && g < 100) begin
      @(negedge HCLK);
      #2;
      g++;
    end
    if (cmd_ready) begin
      c.w = w; c.a = a; c.d = d; c.acc = cyc;
      exp_q.push_back(c);
    end else begin
      check("accept_timeout", 32'(cmd_ready), 32'h1);
    end
    @(negedge HCLK);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    int g;
    g = 0;
    while (lat_q.size() < n && g < 200) begin
      @(negedge HCLK);
      g++;
    end
    #2;
    check("rsp_count", lat_q.size(), n);
    @(negedge HCLK);
  endtask

  task automatic clr_log();
    lat_q.delete(); rd_q.delete(); err_q.delete();
  endtask

  initial begin : main
    int          n;
    int          g;
    logic [31:0] a;
    HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;

    // reset state
    @(negedge HCLK);
    check("rst_htrans", 32'(HTRANS), 32'h0);
    check("rst_haddr", HADDR, 32'h0);
    check("rst_hwrite", 32'(HWRITE), 32'h0);
    check("rst_hwdata", HWDATA, 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'h0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'h0);
    check("hsize", 32'(HSIZE), 32'h2);
    check("hburst", 32'(HBURST), 32'h0);
    check("hprot", 32'(HPROT), 32'h3);
    repeat (2) @(negedge HCLK);
    #3 HRESETn = 1'b1;
    @(negedge HCLK);

    // single write, zero wait states
    clr_log();
    issue(1'b1, 32'h5300_0004, 32'h1);
    check("w1_htrans", 32'(HTRANS), 32'h2);
    check("w1_haddr", HADDR, 32'h5300_0004);
    check("w1_hwrite", 32'(HWRITE), 32'h1);
    @(negedge HCLK);
    check("w1_idle", 32'(HTRANS), 32'h0);
    check("w1_hwdata", HWDATA, 32'h1);
    wait_rsp(1);
    check("w1_latency", lat_q[0], 3);
    check("w1_err", 32'(err_q[0]), 32'h0);

    // write then read back-to-back
    clr_log();
    issue(1'b1, 32'h5300_0000, 32'h0000_A5A5);
    check("wr_nonseq0", 32'(HTRANS), 32'h2);
    issue(1'b0, 32'h5300_0000, 32'h0);
    check("wr_nonseq1", 32'(HTRANS), 32'h2);
    check("wr_hwrite1", 32'(HWRITE), 32'h0);
    wait_rsp(2);
    check("wr_rdata", rd_q[1], 32'h0000_A5A5);
    check("wr_latency1", lat_q[1], 3);

    // read with two wait states
    clr_log();
    dir_waits = 2;
    issue(1'b0, 32'h5300_0000, 32'h0);
    wait_rsp(1);
    check("ws_latency", lat_q[0], 5);
    check("ws_rdata", rd_q[0], 32'h0000_A5A5);
    dir_waits = 0;

    // ERROR on write A with read B queued behind it
    clr_log();
    issue(1'b1, 32'hE000_0010, 32'h1234_5678);
    issue(1'b0, 32'h5300_0020, 32'h0);
    check("err_b_nonseq", 32'(HTRANS), 32'h2);
    @(negedge HCLK);
    check("err_idle", 32'(HTRANS), 32'h0);
    check("err_haddr_kept", HADDR, 32'h5300_0020);
    @(negedge HCLK);
    check("err_idle2", 32'(HTRANS), 32'h0);
    @(negedge HCLK);
    check("err_reissue", 32'(HTRANS), 32'h2);
    check("err_reissue_addr", HADDR, 32'h5300_0020);
    wait_rsp(2);
    check("err_a_err", 32'(err_q[0]), 32'h1);
    check("err_b_err", 32'(err_q[1]), 32'h0);
    check("err_a_latency", lat_q[0], 4);
    check("err_b_latency", lat_q[1], 6);
    check("err_b_rdata", rd_q[1], init_word(30'h14C0_0008));

    // reset while a data phase is stalled
    clr_log();
    dir_waits = 6;
    issue(1'b1, 32'h5300_0040, 32'hDEAD_BEEF);
    @(negedge HCLK);
    #1 check("rstm_pre_hwdata", HWDATA, 32'hDEAD_BEEF);
    #2 HRESETn = 1'b0;
    exp_q.delete();
    #1;
    check("rstm_htrans", 32'(HTRANS), 32'h0);
    check("rstm_haddr", HADDR, 32'h0);
    check("rstm_hwrite", 32'(HWRITE), 32'h0);
    check("rstm_hwdata", HWDATA, 32'h0);
    check("rstm_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rstm_cmd_ready", 32'(cmd_ready), 32'h0);
    repeat (2) @(negedge HCLK);
    dir_waits = 0;
    #3 HRESETn = 1'b1;
    @(negedge HCLK);
    n = lat_q.size();
    repeat (8) @(negedge HCLK);
    check("rstm_no_rsp", lat_q.size(), n);
    issue(1'b0, 32'h5300_0040, 32'h0);
    wait_rsp(n + 1);
    check("rstm_next_latency", lat_q[n], 3);
    check("rstm_next_rdata", rd_q[n], init_word(30'h14C0_0010));

    // unaligned address
    clr_log();
    issue(1'b0, 32'h5300_0007, 32'h0);
    check("align_haddr", HADDR, 32'h5300_0004);
    wait_rsp(1);

    // randomized traffic
    s_rand = 1'b1;
    for (int i = 0; i < 250; i++) begin
      a = (($urandom_range(0, 7) == 0) ? 32'hE000_0000 : 32'h5300_0000)
          | ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
      issue(1'($urandom_range(0, 1)), a, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge HCLK);
    end
    g = 0;
    while (exp_q.size() != 0 && g < 3000) begin
      @(negedge HCLK);
      g++;
    end
    #2;
    check("drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
